// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter with bounded bursts in front of one val/wait memory port.
// Optional perf counters are compiled in when MEM_ARBITER_PERF_EN is defined.
module mem_arbiter #(
    parameter int unsigned BURST_MAX = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_val,
    output logic        req0_wait,
    input  logic        req0_type,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic [31:0] req0_rdata,
    input  logic        req1_val,
    output logic        req1_wait,
    input  logic        req1_type,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic [31:0] req1_rdata,
    output logic        mem_val,
    input  logic        mem_wait,
    output logic        mem_type,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef MEM_ARBITER_PERF_EN
    ,
    output logic [31:0] perf_done0,
    output logic [31:0] perf_done1,
    output logic [31:0] perf_conflict
`endif
);

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    logic       lock;
    logic       lock_id;
    logic       last_id;
    logic [3:0] burst_cnt;

    logic       grant;
    logic       active;
    logic       done;

    // A held lock wins outright; otherwise a tie goes to last_id until its burst is used up.
    always_comb begin
        grant = 1'b0;
        if (lock) begin
            grant = lock_id;
        end else if (req0_val && req1_val) begin
            grant = (burst_cnt < BURST_LIM) ? last_id : ~last_id;
        end else if (req1_val) begin
            grant = 1'b1;
        end
    end

    // NOTE: reset is synchronous, so the port outputs are gated by rst combinationally
    // to keep memory idle and both requesters stalled during the reset cycle itself.
    assign active = ~rst & (grant ? req1_val : req0_val);
    assign done   = active & ~mem_wait;

    always_comb begin
        mem_val    = active;
        mem_type   = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        req0_rdata = 32'h0;
        req1_rdata = 32'h0;
        if (active) begin
            mem_type  = grant ? req1_type  : req0_type;
            mem_addr  = grant ? req1_addr  : req0_addr;
            mem_wdata = grant ? req1_wdata : req0_wdata;
            if (!grant && !req0_type) req0_rdata = mem_rdata;
            if (grant && !req1_type)  req1_rdata = mem_rdata;
        end
    end

    always_comb begin
        req0_wait = 1'b0;
        req1_wait = 1'b0;
        if (rst) begin
            req0_wait = 1'b1;
            req1_wait = 1'b1;
        end else begin
            if (req0_val) req0_wait = grant ? 1'b1 : mem_wait;
            if (req1_val) req1_wait = grant ? mem_wait : 1'b1;
        end
    end

    // Lock follows "granted request stalled"; completion, a dropped val or reset all clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock      <= 1'b0;
            lock_id   <= 1'b0;
            last_id   <= 1'b1;
            burst_cnt <= BURST_LIM;
        end else begin
            lock <= active & mem_wait;
            if (active && mem_wait) lock_id <= grant;
            if (done) begin
                if (grant == last_id) begin
                    if (burst_cnt != 4'hf) burst_cnt <= burst_cnt + 4'd1;
                end else begin
                    last_id   <= grant;
                    burst_cnt <= 4'd1;
                end
            end
        end
    end

`ifdef MEM_ARBITER_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_done0    <= 32'h0;
            perf_done1    <= 32'h0;
            perf_conflict <= 32'h0;
        end else begin
            if (done && !grant) perf_done0 <= perf_done0 + 32'd1;
            if (done && grant)  perf_done1 <= perf_done1 + 32'd1;
            if (req0_val && req1_val) perf_conflict <= perf_conflict + 32'd1;
        end
    end
`endif

    // Dropping val while locked is a requester protocol violation.
    a_locked_val_held: assert property (
        @(posedge clk) disable iff (rst) lock |-> (lock_id ? req1_val : req0_val)
    );

endmodule
